// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: shares one resource among 2**ENCODE_WIDTH requesters
// with registered one-hot/encoded grant outputs and an optional hold-time limit.

module bin_to_onehot #(
  parameter int unsigned ENCODE_WIDTH = 4,
  parameter int unsigned DECODE_WIDTH = 2 ** ENCODE_WIDTH
) (
  input  logic                    en,
  input  logic [ENCODE_WIDTH-1:0] idx,
  output logic [DECODE_WIDTH-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

module rr_grant_scheduler #(
  parameter int unsigned ENCODE_WIDTH = 4,
  parameter int unsigned MAX_HOLD     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [(2**ENCODE_WIDTH)-1:0] req,
  input  logic                         release_grant,
  output logic [(2**ENCODE_WIDTH)-1:0] grant,
  output logic [ENCODE_WIDTH-1:0]      grant_idx,
  output logic                         grant_valid,
  output logic                         timeout
);

  localparam int unsigned DECODE_WIDTH = 2 ** ENCODE_WIDTH;
  localparam int unsigned HOLD_WIDTH   = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned HOLD_LAST    = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam bit          TIMEOUT_EN   = (MAX_HOLD != 0);

  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST_V = HOLD_WIDTH'(HOLD_LAST);
  localparam logic [HOLD_WIDTH-1:0] HOLD_SAT_V  = '1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  state, state_d;
  logic [ENCODE_WIDTH-1:0] ptr, ptr_d;
  logic [HOLD_WIDTH-1:0]   hold_cnt, hold_d;
  logic [ENCODE_WIDTH-1:0] idx_d;
  logic                    valid_d;
  logic                    timeout_d;
  logic [DECODE_WIDTH-1:0] grant_d;

  logic                    win_found;
  logic [ENCODE_WIDTH-1:0] win_idx;
  logic [ENCODE_WIDTH-1:0] cand;

  // Circular priority search starting at ptr; first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < DECODE_WIDTH; k++) begin
      cand = ptr + ENCODE_WIDTH'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    hold_d    = hold_cnt;
    idx_d     = grant_idx;
    valid_d   = grant_valid;
    timeout_d = 1'b0;

    case (state)
      IDLE: begin
        idx_d   = '0;
        valid_d = 1'b0;
        if (win_found) begin
          idx_d   = win_idx;
          valid_d = 1'b1;
          hold_d  = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (release_grant || !req[grant_idx]) begin
          state_d = IDLE;
          ptr_d   = grant_idx + ENCODE_WIDTH'(1);
          idx_d   = '0;
          valid_d = 1'b0;
        end else if (TIMEOUT_EN && (hold_cnt == HOLD_LAST_V)) begin
          state_d   = IDLE;
          ptr_d     = grant_idx + ENCODE_WIDTH'(1);
          idx_d     = '0;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
        end else if (hold_cnt != HOLD_SAT_V) begin
          hold_d = hold_cnt + HOLD_WIDTH'(1);
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // One-hot form is always derived from the next index, so grant tracks grant_idx.
  bin_to_onehot #(
    .ENCODE_WIDTH(ENCODE_WIDTH),
    .DECODE_WIDTH(DECODE_WIDTH)
  ) u_dec (
    .en    (valid_d),
    .idx   (idx_d),
    .onehot(grant_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      hold_cnt    <= hold_d;
      grant       <= grant_d;
      grant_idx   <= idx_d;
      grant_valid <= valid_d;
      timeout     <= timeout_d;
    end
  end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed self-checking bench for rr_grant_scheduler (ENCODE_WIDTH=4, MAX_HOLD=8).

module tb_rr_grant_scheduler;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        release_grant;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  int n_total;
  int n_bad;

  rr_grant_scheduler #(
    .ENCODE_WIDTH(4),
    .MAX_HOLD    (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .release_grant(release_grant),
    .grant        (grant),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare all four outputs against an expected owner (valid=0 means no grant).
  task automatic check_out(input string tag, input logic v, input logic [3:0] idx,
                           input logic to);
    logic [15:0] g;
    g = '0;
    if (v) g[idx] = 1'b1;
    check_eq({tag, ".valid"},   32'(grant_valid), 32'(v));
    check_eq({tag, ".idx"},     32'(grant_idx),   v ? 32'(idx) : 32'd0);
    check_eq({tag, ".grant"},   32'(grant),       32'(g));
    check_eq({tag, ".timeout"}, 32'(timeout),     32'(to));
  endtask

  // Advance through one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_total       = 0;
    n_bad         = 0;
    rst           = 1'b1;
    req           = '0;
    release_grant = 1'b0;

    repeat (2) tick();
    check_out("reset", 1'b0, 4'd0, 1'b0);
    rst = 1'b0;

    // Basic grant and release.
    req = 16'h0001;
    tick();
    check_out("basic_grant", 1'b1, 4'd0, 1'b0);
    release_grant = 1'b1;
    tick();
    check_out("basic_release", 1'b0, 4'd0, 1'b0);
    release_grant = 1'b0;
    req = '0;
    tick();

    // All requesting: ptr is 1, so owners run 1..15, 0, 1 with an idle cycle between.
    req = 16'hFFFF;
    for (int i = 0; i < 17; i++) begin
      tick();
      check_out($sformatf("rr_%0d", i), 1'b1, 4'((1 + i) % 16), 1'b0);
      release_grant = 1'b1;
      tick();
      check_out($sformatf("rr_gap_%0d", i), 1'b0, 4'd0, 1'b0);
      release_grant = 1'b0;
    end
    req = '0;
    tick();

    // ptr is 2: grant 4 moves ptr to 5, so 9 beats 3.
    req = 16'h0010;
    tick();
    check_out("ptr5_setup", 1'b1, 4'd4, 1'b0);
    release_grant = 1'b1;
    req = 16'h0208;
    tick();
    release_grant = 1'b0;
    tick();
    check_out("ptr5_first", 1'b1, 4'd9, 1'b0);
    release_grant = 1'b1;
    tick();
    release_grant = 1'b0;
    req = 16'h0008;
    tick();
    check_out("ptr5_second", 1'b1, 4'd3, 1'b0);
    release_grant = 1'b1;
    req = 16'h0000;
    tick();
    release_grant = 1'b0;

    // Timeout: ptr is 4, owner 0 holds exactly 8 cycles, then idle with pulse, then owner 1.
    req = 16'h0003;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_out($sformatf("hold_%0d", i), 1'b1, 4'd0, 1'b0);
    end
    tick();
    check_out("timeout_pulse", 1'b0, 4'd0, 1'b1);
    tick();
    check_out("after_timeout", 1'b1, 4'd1, 1'b0);
    release_grant = 1'b1;
    req = 16'h0000;
    tick();
    release_grant = 1'b0;

    // Release coincides with the last allowed hold cycle: normal end, no timeout.
    req = 16'h0004;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) check_out("late_rel_grant", 1'b1, 4'd2, 1'b0);
    end
    check_out("late_rel_hold", 1'b1, 4'd2, 1'b0);
    release_grant = 1'b1;
    tick();
    check_out("late_rel_end", 1'b0, 4'd0, 1'b0);
    release_grant = 1'b0;
    req = 16'h0000;
    tick();

    // Owner drops its request mid-grant; ptr advances past it.
    req = 16'h0008;
    tick();
    check_out("drop_grant", 1'b1, 4'd3, 1'b0);
    req = 16'h0000;
    tick();
    check_out("drop_end", 1'b0, 4'd0, 1'b0);
    req = 16'h0018;
    tick();
    check_out("drop_ptr", 1'b1, 4'd4, 1'b0);
    release_grant = 1'b1;
    req = 16'h0000;
    tick();
    release_grant = 1'b0;

    // Asynchronous reset in the middle of a grant; ptr returns to 0.
    req = 16'h0001;
    tick();
    check_out("pre_rst_grant", 1'b1, 4'd0, 1'b0);
    #2 rst = 1'b1;
    #1 check_out("async_rst", 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    req = 16'h8001;
    tick();
    check_out("post_rst_grant", 1'b1, 4'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
